// File: rtl/down_counter_timer_pkg.sv
// Shared state encoding for the loadable down-counter/timer.
package down_counter_timer_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_timer_tick_prescaler.sv
// Enable-gated prescaler: emits one tick every PRESCALE enabled cycles.
// With PRESCALE=1 the tick is simply the enable input.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next prescaler count: clear wins, otherwise advance and wrap on enabled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with valid/ready load, one-cycle done pulse,
// optional auto-reload and abort.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             auto_reload,
  input  logic             abort,
  output logic [WIDTH-1:0] counter_out,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tick;
  logic             presc_clear;

  // Holding the prescaler cleared outside RUN gives it a zero start on every
  // load and reload without a separate clear path; abort clears it in RUN.
  assign presc_clear = (state_q != ST_RUN) || abort;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .clear (presc_clear),
    .tick  (tick)
  );

  // Next-state, counter and reload-register logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          count_d  = load_value;
          reload_d = load_value;
          state_d  = (load_value != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else if (tick) begin
          if (count_q == WIDTH'(1)) begin
            count_d = '0;
            state_d = ST_DONE;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (abort) begin
          count_d = '0;
          state_d = ST_IDLE;
        end else if (auto_reload && (reload_q != '0)) begin
          count_d = reload_q;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and reload registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  assign counter_out = count_q;
  assign load_ready  = (state_q == ST_IDLE);
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench: stimulus schedules expected output values per cycle,
// a monitor pops and compares them on the falling edge.
module tb_down_counter_timer;

  localparam int unsigned K_CNT  = 0;
  localparam int unsigned K_DONE = 1;
  localparam int unsigned K_BUSY = 2;
  localparam int unsigned K_LR   = 3;
  localparam int unsigned K_PEND = 4;
  localparam int unsigned DA = 0;
  localparam int unsigned DB = 1;

  typedef struct {
    int unsigned cyc;
    int unsigned dut;
    int unsigned kind;
    int unsigned val;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic       en_a = 1'b0, lv_a = 1'b0, ar_a = 1'b0, ab_a = 1'b0;
  logic [3:0] lval_a = '0;
  logic       lr_a, busy_a, done_a;
  logic [3:0] cnt_a;

  logic       en_b = 1'b0, lv_b = 1'b0, ar_b = 1'b0, ab_b = 1'b0;
  logic [3:0] lval_b = '0;
  logic       lr_b, busy_b, done_b;
  logic [3:0] cnt_b;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t sbq[$];
  exp_t immq[$];
  event imm_ev;

  down_counter_timer #(.WIDTH(4), .PRESCALE(1)) u_a (
    .clock(clock), .reset(reset), .enable(en_a), .load_valid(lv_a),
    .load_value(lval_a), .load_ready(lr_a), .auto_reload(ar_a), .abort(ab_a),
    .counter_out(cnt_a), .busy(busy_a), .done(done_a)
  );

  down_counter_timer #(.WIDTH(4), .PRESCALE(3)) u_b (
    .clock(clock), .reset(reset), .enable(en_b), .load_valid(lv_b),
    .load_value(lval_b), .load_ready(lr_b), .auto_reload(ar_b), .abort(ab_b),
    .counter_out(cnt_b), .busy(busy_b), .done(done_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic string kname(int unsigned k);
    case (k)
      K_CNT:   return "counter_out";
      K_DONE:  return "done";
      K_BUSY:  return "busy";
      K_LR:    return "load_ready";
      default: return "pending_expectations";
    endcase
  endfunction

  function automatic int unsigned actual(int unsigned d, int unsigned k);
    case (k)
      K_CNT:   return (d == DA) ? int'(cnt_a)  : int'(cnt_b);
      K_DONE:  return (d == DA) ? int'(done_a) : int'(done_b);
      K_BUSY:  return (d == DA) ? int'(busy_a) : int'(busy_b);
      K_LR:    return (d == DA) ? int'(lr_a)   : int'(lr_b);
      default: return sbq.size();
    endcase
  endfunction

  function automatic void sb_push(int unsigned c, int unsigned d, int unsigned k, int unsigned v);
    exp_t e;
    int unsigned i;
    e = '{c, d, k, v};
    i = 0;
    while (i < sbq.size() && sbq[i].cyc <= c) i++;
    sbq.insert(i, e);
  endfunction

  function automatic void imm_push(int unsigned d, int unsigned k, int unsigned v);
    exp_t e;
    e = '{0, d, k, v};
    immq.push_back(e);
  endfunction

  task automatic check(input exp_t e);
    int unsigned a;
    a = actual(e.dut, e.kind);
    checks++;
    if (a != e.val) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d: actual=%0d required=%0d",
               kname(e.kind), e.dut, cyc, a, e.val);
    end
  endtask

  // Monitor: compare every expectation due at this falling edge, plus any
  // immediate (between-edge) expectations when signalled.
  always begin
    exp_t e;
    @(negedge clock or imm_ev);
    while (immq.size() > 0) begin
      e = immq.pop_front();
      check(e);
    end
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      check(e);
    end
  end

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic push_idle(input int unsigned c, input int unsigned d);
    sb_push(c, d, K_CNT, 0);
    sb_push(c, d, K_DONE, 0);
    sb_push(c, d, K_BUSY, 0);
    sb_push(c, d, K_LR, 1);
  endtask

  initial begin
    int unsigned c;
    int unsigned p;
    int unsigned pause_tbl[8];
    pause_tbl = '{5, 4, 3, 3, 3, 3, 2, 1};

    // Power-on reset, then both instances idle.
    repeat (2) @(negedge clock);
    reset = 1'b0;
    c = cyc;
    push_idle(c + 1, DA);
    push_idle(c + 1, DB);
    wait_until(c + 2);

    // Load 5, PRESCALE=1, enable high.
    c = cyc;
    en_a = 1'b1; lval_a = 4'd5; lv_a = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      sb_push(c + 1 + k, DA, K_CNT, 5 - k);
      sb_push(c + 1 + k, DA, K_DONE, 0);
    end
    sb_push(c + 1, DA, K_BUSY, 1);
    sb_push(c + 1, DA, K_LR, 0);
    sb_push(c + 6, DA, K_CNT, 0);
    sb_push(c + 6, DA, K_DONE, 1);
    sb_push(c + 6, DA, K_BUSY, 1);
    push_idle(c + 7, DA);
    @(negedge clock);
    lv_a = 1'b0;
    wait_until(c + 8);

    // Load 5 with enable dropped for 3 cycles while the count is 3.
    c = cyc;
    lval_a = 4'd5; lv_a = 1'b1;
    for (int unsigned k = 0; k < 8; k++) begin
      sb_push(c + 1 + k, DA, K_CNT, pause_tbl[k]);
      sb_push(c + 1 + k, DA, K_DONE, 0);
    end
    sb_push(c + 9, DA, K_CNT, 0);
    sb_push(c + 9, DA, K_DONE, 1);
    push_idle(c + 10, DA);
    @(negedge clock);
    lv_a = 1'b0;
    wait_until(c + 3);
    en_a = 1'b0;
    wait_until(c + 6);
    en_a = 1'b1;
    wait_until(c + 11);

    // PRESCALE=3, load 2 with auto-reload: 7-cycle period, three done pulses.
    c = cyc;
    en_b = 1'b1; ar_b = 1'b1; lval_b = 4'd2; lv_b = 1'b1;
    for (int unsigned t = 1; t <= 21; t++) begin
      p = (t - 1) % 7;
      sb_push(c + t, DB, K_CNT, (p < 3) ? 2 : (p < 6) ? 1 : 0);
      sb_push(c + t, DB, K_DONE, (p == 6) ? 1 : 0);
      sb_push(c + t, DB, K_BUSY, 1);
    end
    push_idle(c + 22, DB);
    @(negedge clock);
    lv_b = 1'b0;
    wait_until(c + 21);
    ar_b = 1'b0;
    wait_until(c + 23);

    // Load 0 with auto-reload: immediate done, then back to IDLE.
    c = cyc;
    lval_a = 4'd0; lv_a = 1'b1; ar_a = 1'b1;
    sb_push(c + 1, DA, K_CNT, 0);
    sb_push(c + 1, DA, K_DONE, 1);
    sb_push(c + 1, DA, K_BUSY, 1);
    sb_push(c + 1, DA, K_LR, 0);
    push_idle(c + 2, DA);
    @(negedge clock);
    lv_a = 1'b0;
    wait_until(c + 2);
    ar_a = 1'b0;
    wait_until(c + 3);

    // Load 4, abort on the terminal-tick edge.
    c = cyc;
    lval_a = 4'd4; lv_a = 1'b1;
    for (int unsigned k = 0; k < 4; k++) sb_push(c + 1 + k, DA, K_CNT, 4 - k);
    push_idle(c + 5, DA);
    sb_push(c + 6, DA, K_DONE, 0);
    @(negedge clock);
    lv_a = 1'b0;
    wait_until(c + 4);
    ab_a = 1'b1;
    @(negedge clock);
    ab_a = 1'b0;
    wait_until(c + 7);

    // Load 4, second load of 9 mid-RUN is ignored.
    c = cyc;
    lval_a = 4'd4; lv_a = 1'b1;
    for (int unsigned k = 0; k < 4; k++) sb_push(c + 1 + k, DA, K_CNT, 4 - k);
    sb_push(c + 2, DA, K_LR, 0);
    sb_push(c + 3, DA, K_LR, 0);
    sb_push(c + 5, DA, K_CNT, 0);
    sb_push(c + 5, DA, K_DONE, 1);
    push_idle(c + 6, DA);
    @(negedge clock);
    lv_a = 1'b0;
    wait_until(c + 2);
    lval_a = 4'd9; lv_a = 1'b1;
    @(negedge clock);
    lv_a = 1'b0;
    wait_until(c + 7);

    // Abort in DONE overrides auto-reload.
    c = cyc;
    lval_a = 4'd1; lv_a = 1'b1; ar_a = 1'b1;
    sb_push(c + 1, DA, K_CNT, 1);
    sb_push(c + 2, DA, K_DONE, 1);
    push_idle(c + 3, DA);
    @(negedge clock);
    lv_a = 1'b0;
    wait_until(c + 2);
    ab_a = 1'b1;
    @(negedge clock);
    ab_a = 1'b0; ar_a = 1'b0;
    wait_until(c + 4);

    // Asynchronous reset mid-count takes effect between clock edges.
    c = cyc;
    lval_a = 4'd5; lv_a = 1'b1;
    sb_push(c + 1, DA, K_CNT, 5);
    sb_push(c + 2, DA, K_CNT, 4);
    sb_push(c + 2, DA, K_BUSY, 1);
    @(negedge clock);
    lv_a = 1'b0;
    wait_until(c + 2);
    #2 reset = 1'b1;
    #1;
    imm_push(DA, K_CNT, 0);
    imm_push(DA, K_DONE, 0);
    imm_push(DA, K_BUSY, 0);
    imm_push(DA, K_LR, 1);
    -> imm_ev;
    #1;
    push_idle(c + 3, DA);
    @(negedge clock);
    reset = 1'b0;
    wait_until(c + 5);

    // Every scheduled expectation must have been consumed.
    #1;
    imm_push(DA, K_PEND, 0);
    -> imm_ev;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
